clksel_ctrl: RTL and testbench

CLKSEL_CTRL -- requirements
Module: clksel_ctrl

---
 rtl/clksel_ctrl_if.sv | 22 ++
 rtl/clksel_ctrl.sv | 88 ++++++++
 tb/tb_clksel_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/clksel_ctrl_if.sv
// clksel_ctrl_if: CPU access, config and clock-switch handshake signals for clksel_ctrl.
interface clksel_ctrl_if;
    logic [23:0] addr;
    logic        vda;
    logic        vpa;
    logic        cfg_wr;
    logic [2:0]  cfg_data;
    logic        hsclk_selected;
    logic        lsclk_selected;
    logic        hsclk_sel;
    logic [1:0]  cpuclk_div_sel;
    logic        cpu_rdy;
    logic [1:0]  state_o;
    modport master (
        output addr, vda, vpa, cfg_wr, cfg_data, hsclk_selected, lsclk_selected,
        input  hsclk_sel, cpuclk_div_sel, cpu_rdy, state_o
    );
    modport slave (
        input  addr, vda, vpa, cfg_wr, cfg_data, hsclk_selected, lsclk_selected,
        output hsclk_sel, cpuclk_div_sel, cpu_rdy, state_o
    );
endinterface

// File: rtl/clksel_ctrl.sv
// clksel_ctrl: drops the CPU to the low-speed clock for slow I/O/ROM accesses and returns after a hold time.
module clksel_ctrl #(
    parameter int HOLD_CYCLES = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic         cpuclk_in,
    input  logic         rst_b,
    clksel_ctrl_if.slave bus
);
    localparam int CW = $clog2(HOLD_CYCLES) + 1;
    localparam int BW = $clog2(SYNC_STAGES + 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
    localparam logic [BW-1:0] BOOT_END  = BW'(SYNC_STAGES);

    typedef enum logic [1:0] {HS_RUN = 2'd0, TO_LS = 2'd1, LS_RUN = 2'd2, TO_HS = 2'd3} state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] hs_chain, ls_chain;
    logic [CW-1:0]          hold_q, hold_d;
    logic [BW-1:0]          boot_q;
    logic [1:0]             div_sel_q;
    logic                   force_slow, hsclk_sel_q, rdy;
    logic                   hs_sync, ls_sync, slow_hit, slow_need, boot_done;

    assign hs_sync   = hs_chain[SYNC_STAGES-1];
    assign ls_sync   = ls_chain[SYNC_STAGES-1];
    assign slow_hit  = (bus.vda | bus.vpa) && bus.addr[23:16] == 8'h00 &&
                       ((bus.addr[15:8] >= 8'hFC && bus.addr[15:8] <= 8'hFE) || bus.addr[15:14] == 2'b10);
    assign slow_need = slow_hit | force_slow;
    // Until the status synchronisers hold real samples the FSM must not start a switch.
    assign boot_done = boot_q == BOOT_END;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        rdy     = 1'b1;
        case (state_q)
            HS_RUN: begin
                rdy = !slow_need;
                if (slow_need && boot_done) state_d = TO_LS;
            end
            TO_LS: begin
                rdy = 1'b0;
                if (ls_sync && !hs_sync) begin
                    state_d = LS_RUN;
                    hold_d  = HOLD_LOAD;
                end
            end
            LS_RUN: begin
                hold_d = slow_need ? HOLD_LOAD : ((|hold_q) ? hold_q - 1'b1 : hold_q);
                if (!slow_need && hold_q == '0) state_d = TO_HS;
            end
            TO_HS: begin
                rdy = 1'b0;
                if (hs_sync && !ls_sync) state_d = HS_RUN;
            end
        endcase
    end

    always_ff @(posedge cpuclk_in or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= HS_RUN;
            hsclk_sel_q <= 1'b1;
            hold_q      <= '0;
            boot_q      <= '0;
            hs_chain    <= '0;
            ls_chain    <= '0;
            div_sel_q   <= 2'b00;
            force_slow  <= 1'b0;
        end else begin
            state_q     <= state_d;
            hsclk_sel_q <= state_d == HS_RUN || state_d == TO_HS;
            hold_q      <= hold_d;
            hs_chain    <= SYNC_STAGES'({hs_chain, bus.hsclk_selected});
            ls_chain    <= SYNC_STAGES'({ls_chain, bus.lsclk_selected});
            if (!boot_done) boot_q <= boot_q + 1'b1;
            if (bus.cfg_wr) begin
                div_sel_q  <= bus.cfg_data[1:0];
                force_slow <= bus.cfg_data[2];
            end
        end
    end

    assign bus.cpu_rdy        = rdy | !rst_b;
    assign bus.hsclk_sel      = hsclk_sel_q;
    assign bus.cpuclk_div_sel = div_sel_q;
    assign bus.state_o        = state_q;
endmodule

// File: tb/tb_clksel_ctrl.sv
// tb_clksel_ctrl: random and directed CPU traffic against a cycle-level model of the clock-select rules.
module tb_clksel_ctrl;
    localparam int HOLD = 4;
    localparam int SYNC = 2;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    clksel_ctrl_if bus();
    clksel_ctrl #(.HOLD_CYCLES(HOLD), .SYNC_STAGES(SYNC)) dut (.cpuclk_in(clk), .rst_b(rst_b), .bus(bus));

    int n_vec = 0;
    int n_bad = 0;

    // model: state number, cycles since reset, consecutive idle LS cycles, config, status pipelines
    int       m_state, m_age, m_streak;
    bit       m_force;
    bit [1:0] m_div;
    bit       hq[$], lq[$];
    bit       sw_tgt, last_rdy;
    int       sw_dly;

    logic [23:0] bnd [10] = '{24'h007FFF, 24'h008000, 24'h00BFFF, 24'h00C000, 24'h00FBFF,
                              24'h00FC00, 24'h00FEFF, 24'h00FF00, 24'h01FD00, 24'h108000};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic bit is_slow(input logic [23:0] a);
        return a <= 24'h00FFFF && ((a >= 24'h00FC00 && a <= 24'h00FEFF) || (a >= 24'h008000 && a <= 24'h00BFFF));
    endfunction

    task automatic model_reset();
        m_state = 0; m_age = 0; m_streak = 0; m_force = 0; m_div = 0;
        hq.delete(); lq.delete();
        repeat (SYNC) begin hq.push_back(1'b0); lq.push_back(1'b0); end
    endtask

    // clock switch: break-before-make, settles 1..3 cycles after a new request
    task automatic sw_update();
        bit req;
        req = (m_state == 0 || m_state == 3);
        if (req != sw_tgt) begin
            sw_tgt = req;
            bus.hsclk_selected = 1'b0;
            bus.lsclk_selected = 1'b0;
            sw_dly = $urandom_range(1, 3);
        end else if (sw_dly > 0) begin
            sw_dly--;
            if (sw_dly == 0) begin
                bus.hsclk_selected = sw_tgt;
                bus.lsclk_selected = !sw_tgt;
            end
        end
    endtask

    task automatic commit(input int nxt, input bit need);
        void'(hq.pop_front()); hq.push_back(bus.hsclk_selected);
        void'(lq.pop_front()); lq.push_back(bus.lsclk_selected);
        m_streak = (m_state == 2 && nxt == 2 && !need) ? m_streak + 1 : 0;
        if (bus.cfg_wr) begin m_force = bus.cfg_data[2]; m_div = bus.cfg_data[1:0]; end
        m_state = nxt;
        if (m_age < SYNC) m_age++;
        sw_update();
    endtask

    task automatic step();
        bit need, rdy, hs_s, ls_s;
        int nxt;
        @(negedge clk);
        hs_s = hq[0];
        ls_s = lq[0];
        need = ((bus.vda | bus.vpa) && is_slow(bus.addr)) || m_force;
        case (m_state)
            0: begin rdy = !need; nxt = (need && m_age >= SYNC) ? 1 : 0; end
            1: begin rdy = 1'b0;  nxt = (ls_s && !hs_s) ? 2 : 1; end
            2: begin rdy = 1'b1;  nxt = (!need && m_streak + 1 >= HOLD) ? 3 : 2; end
            default: begin rdy = 1'b0; nxt = (hs_s && !ls_s) ? 0 : 3; end
        endcase
        chk("state_o", bus.state_o, m_state);
        chk("hsclk_sel", bus.hsclk_sel, m_state == 0 || m_state == 3);
        chk("cpu_rdy", bus.cpu_rdy, rdy);
        chk("div_sel", bus.cpuclk_div_sel, m_div);
        last_rdy = rdy;
        @(posedge clk); #1;
        commit(nxt, need);
    endtask

    task automatic do_reset();
        bus.cfg_wr = 1'b0;
        rst_b = 1'b0;
        #1;
        chk("rst_state", bus.state_o, 0);
        chk("rst_hsclk_sel", bus.hsclk_sel, 1);
        chk("rst_cpu_rdy", bus.cpu_rdy, 1);
        chk("rst_div_sel", bus.cpuclk_div_sel, 0);
        model_reset();
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk); #1;
        commit(0, 1'b0);
        last_rdy = 1'b1;
    endtask

    task automatic access(input logic [23:0] a, input bit da, input bit pa);
        int g = 0;
        bus.addr = a; bus.vda = da; bus.vpa = pa; bus.cfg_wr = 1'b0;
        do begin step(); g++; end while (!last_rdy && g < 60);
        if (g >= 60) chk("access_timeout", g, 0);
        bus.vda = 1'b0; bus.vpa = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.vda = 1'b0; bus.vpa = 1'b0; bus.cfg_wr = 1'b0;
        repeat (n) step();
    endtask

    task automatic wait_state(input int s);
        int g = 0;
        bus.vda = 1'b0; bus.vpa = 1'b0; bus.cfg_wr = 1'b0;
        while (m_state != s && g < 60) begin step(); g++; end
        if (g >= 60) chk("wait_state_timeout", g, 0);
    endtask

    task automatic cfg(input logic [2:0] d);
        bus.vda = 1'b0; bus.vpa = 1'b0;
        bus.cfg_wr = 1'b1; bus.cfg_data = d;
        step();
        bus.cfg_wr = 1'b0;
    endtask

    task automatic rand_cycle();
        int k;
        if (last_rdy) begin
            k = $urandom_range(0, 9);
            case (k)
                4:       bus.addr = 24'h00FC00 + 24'($urandom_range(0, 'h2FF));
                5:       bus.addr = 24'h008000 + 24'($urandom_range(0, 'h3FFF));
                6:       bus.addr = 24'($urandom_range(0, 'h7FFF));
                8:       bus.addr = bnd[$urandom_range(0, 9)];
                9:       bus.addr = 24'h00C000 + 24'($urandom_range(0, 'h3BFF));
                default: bus.addr = 24'($urandom);
            endcase
            {bus.vda, bus.vpa} = (k < 4) ? 2'b00 : 2'($urandom_range(1, 3));
        end
        bus.cfg_wr = ($urandom_range(0, 39) == 0);
        bus.cfg_data = {($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3))};
        step();
    endtask

    initial begin
        bus.addr = '0; bus.vda = 1'b0; bus.vpa = 1'b0; bus.cfg_wr = 1'b0; bus.cfg_data = '0;
        bus.hsclk_selected = 1'b1; bus.lsclk_selected = 1'b0;
        sw_tgt = 1'b1; sw_dly = 0; last_rdy = 1'b1;
        @(posedge clk); #1;
        do_reset();
        bus.addr = 24'h001000; bus.vda = 1'b1;
        repeat (6) step();
        access(24'h00FE40, 1'b1, 1'b0);
        idle(HOLD + 8);
        access(24'h008000, 1'b1, 1'b0); idle(2);
        access(24'h00BFFF, 1'b0, 1'b1); idle(2);
        access(24'h00FC00, 1'b1, 1'b0); idle(HOLD + 8);
        access(24'h00FD00, 1'b1, 1'b0);
        wait_state(3);
        access(24'h00FEFF, 1'b0, 1'b1);
        idle(HOLD + 8);
        cfg(3'b110); idle(12);
        cfg(3'b010); idle(HOLD + 12);
        bus.addr = 24'h00FE40; bus.vda = 1'b1;
        step();
        chk("pre_rst_state", bus.state_o, 1);
        chk("pre_rst_hsclk_sel", bus.hsclk_sel, 0);
        do_reset();
        access(24'h00FE40, 1'b1, 1'b0);
        idle(HOLD + 8);
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 499) == 0) do_reset();
            rand_cycle();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
